ofs_plat_avalon_mem_rdwr_if_allowance_sink: RTL and testbench
=============================================================

OFS_PLAT_AVALON_MEM_RDWR_IF_ALLOWANCE_SINK -- requirements
Module: ofs_plat_avalon_mem_rdwr_if_allowance_sink

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, the address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 512, the write data width; byteenable width is DATA_WIDTH/8.
REQ-003 SHALL have parameter BURST_CNT_WIDTH, default 7, the burstcount width.
REQ-004 SHALL have parameter WAIT_REQUEST_ALLOWANCE, default 2, the number of requests the source may issue after seeing waitrequest.
REQ-005 SHALL have parameter FIFO_DEPTH, default 8, the per-channel entry count; FIFO_DEPTH >= WAIT_REQUEST_ALLOWANCE+2 is required.
REQ-006 clk  in  1  sole clock; all logic on posedge.
REQ-007 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-008 src_rd_read / src_rd_address / src_rd_burstcount  in  1/ADDR_WIDTH/BURST_CNT_WIDTH  upstream read command (allowance protocol).
REQ-009 src_rd_waitrequest  out  1  upstream read backpressure, registered.
REQ-010 src_wr_write / src_wr_address / src_wr_burstcount / src_wr_writedata / src_wr_byteenable  in  1/ADDR_WIDTH/BURST_CNT_WIDTH/DATA_WIDTH/DATA_WIDTH/8  upstream write beat.
REQ-011 src_wr_waitrequest  out  1  upstream write backpressure, registered.
REQ-012 snk_rd_read / snk_rd_address / snk_rd_burstcount  out  as REQ-008  downstream read command (strict waitrequest).
REQ-013 snk_rd_waitrequest  in  1  downstream read backpressure.
REQ-014 snk_wr_write / snk_wr_address / snk_wr_burstcount / snk_wr_writedata / snk_wr_byteenable  out  as REQ-010  downstream write beat.
REQ-015 snk_wr_waitrequest  in  1  downstream write backpressure.
REQ-016 overflow_err  out  2  sticky overflow flags, bit0 read, bit1 write.

Function
REQ-017 Each channel SHALL own an independent FIFO of FIFO_DEPTH entries; read and write channels never interact; responses do not pass through this block.
REQ-018 A push SHALL occur on any cycle with src_rd_read (src_wr_write) high, regardless of src_*_waitrequest.
REQ-019 A pop SHALL occur when snk_*_read/write is high and snk_*_waitrequest is low.
REQ-020 snk_rd_read (snk_wr_write) SHALL equal FIFO non-empty; command fields SHALL be the head entry and hold stable while waitrequest is high.
REQ-021 Latency: command pushed at edge t SHALL appear on the sink side after edge t (no combinational fall-through), FIFO order preserved.
REQ-022 Each write beat SHALL be one entry; burstcount SHALL be forwarded unmodified, with no burst interpretation.
REQ-023 src_*_waitrequest SHALL register (count_next > FIFO_DEPTH - WAIT_REQUEST_ALLOWANCE - 1), count_next being the post-push/pop occupancy.
REQ-024 Simultaneous push and pop SHALL leave count unchanged, including at full and at empty (empty case: entry passes through with 1-cycle latency).
REQ-025 Push while full without pop SHALL be an overflow: entry dropped, count unchanged, handled per REQ-029/030.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; FIFO_DEPTH need not be a power of two.

Reset
REQ-027 While reset_n low: FIFOs empty, snk_rd_read=0, snk_wr_write=0, src_*_waitrequest=1, overflow_err=0.
REQ-028 src_*_waitrequest SHALL deassert at the first posedge after reset_n rises; reset mid-traffic discards all queued entries.

Configuration
REQ-029 With OFS_PLAT_AVALON_ALLOWANCE_CHECK_EN defined, overflow SHALL set the matching overflow_err bit until reset, and a simulation assertion SHALL fire.
REQ-030 Without OFS_PLAT_AVALON_ALLOWANCE_CHECK_EN, overflow_err SHALL be tied to 0, no checker logic SHALL be built, and overflow drops silently.

Verification
REQ-031 Reset release, single read to 0x100 burst 4, sink ready -> snk_rd_read high exactly one cycle, address 0x100, burstcount 4, one cycle after push.
REQ-032 Sink write waitrequest held high, source writes every cycle honoring allowance 2 -> exactly 8 beats queued, src_wr_waitrequest high from count 6 onward, overflow_err=0, data order intact on release.
REQ-033 Both channels full, simultaneous push/pop on each for 20 cycles -> count stays 8, no drops, per-channel order preserved.
REQ-034 Macro defined, 9th write pushed while full and sink stalled -> overflow_err=2'b10 sticky, 8 original beats delivered; macro undefined -> overflow_err=0.
REQ-035 reset_n pulsed low with 5 queued reads -> snk_rd_read drops asynchronously, src_rd_waitrequest=1, no stale entry appears after release.

Source files
------------

// File: rtl/ofs_plat_avalon_mem_rdwr_if_allowance_sink.sv
// Avalon read/write allowance sink: converts a source that may keep issuing
// WAIT_REQUEST_ALLOWANCE commands after seeing waitrequest into a sink that
// honours strict waitrequest. Each channel is an independent FIFO.
// Optional build macro: OFS_PLAT_AVALON_ALLOWANCE_CHECK_EN (sticky overflow
// flags plus simulation assertion); without it overflow drops silently.

// One channel: FIFO with registered allowance-aware waitrequest.
module ofs_plat_avalon_allowance_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int ALLOWANCE = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             waitrequest,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  input  logic             ready,
  output logic             overflow_err
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] WR_THRESH = CNT_W'(DEPTH - ALLOWANCE - 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count, count_next;
  logic             pop, push_ok;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign valid   = (count != '0);
  assign head    = mem[rd_ptr];
  assign pop     = valid & ready;
  // At full a push is only accepted if the head leaves in the same cycle.
  assign push_ok = push & ((count != FULL_CNT) | pop);

  // Post-push/pop occupancy, used for both the count and waitrequest.
  always_comb begin
    count_next = count;
    if (push_ok && !pop)      count_next = count + 1'b1;
    else if (!push_ok && pop) count_next = count - 1'b1;
  end

  // Pointer/count state and registered backpressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      waitrequest <= 1'b1;
    end else begin
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      count       <= count_next;
      waitrequest <= (count_next > WR_THRESH);
    end
  end

  // Storage; contents are qualified by count so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

`ifdef OFS_PLAT_AVALON_ALLOWANCE_CHECK_EN
  logic overflow;
  assign overflow = push & ~push_ok;

  // Sticky flag: a source that exceeded its allowance lost a command.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      overflow_err <= 1'b0;
    else if (overflow) overflow_err <= 1'b1;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) !overflow)
    else $error("allowance FIFO overflow, command dropped");
`else
  assign overflow_err = 1'b0;
`endif
endmodule

// Top: independent read and write channels.
module ofs_plat_avalon_mem_rdwr_if_allowance_sink #(
  parameter int ADDR_WIDTH             = 32,
  parameter int DATA_WIDTH             = 512,
  parameter int BURST_CNT_WIDTH        = 7,
  parameter int WAIT_REQUEST_ALLOWANCE = 2,
  parameter int FIFO_DEPTH             = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       src_rd_read,
  input  logic [ADDR_WIDTH-1:0]      src_rd_address,
  input  logic [BURST_CNT_WIDTH-1:0] src_rd_burstcount,
  output logic                       src_rd_waitrequest,
  input  logic                       src_wr_write,
  input  logic [ADDR_WIDTH-1:0]      src_wr_address,
  input  logic [BURST_CNT_WIDTH-1:0] src_wr_burstcount,
  input  logic [DATA_WIDTH-1:0]      src_wr_writedata,
  input  logic [DATA_WIDTH/8-1:0]    src_wr_byteenable,
  output logic                       src_wr_waitrequest,
  output logic                       snk_rd_read,
  output logic [ADDR_WIDTH-1:0]      snk_rd_address,
  output logic [BURST_CNT_WIDTH-1:0] snk_rd_burstcount,
  input  logic                       snk_rd_waitrequest,
  output logic                       snk_wr_write,
  output logic [ADDR_WIDTH-1:0]      snk_wr_address,
  output logic [BURST_CNT_WIDTH-1:0] snk_wr_burstcount,
  output logic [DATA_WIDTH-1:0]      snk_wr_writedata,
  output logic [DATA_WIDTH/8-1:0]    snk_wr_byteenable,
  input  logic                       snk_wr_waitrequest,
  output logic [1:0]                 overflow_err
);
  typedef struct packed {
    logic [ADDR_WIDTH-1:0]      address;
    logic [BURST_CNT_WIDTH-1:0] burstcount;
  } rd_cmd_t;

  // Each write beat is one entry; burstcount travels untouched.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0]      address;
    logic [BURST_CNT_WIDTH-1:0] burstcount;
    logic [DATA_WIDTH-1:0]      writedata;
    logic [DATA_WIDTH/8-1:0]    byteenable;
  } wr_cmd_t;

  rd_cmd_t rd_in, rd_head;
  wr_cmd_t wr_in, wr_head;

  assign rd_in.address    = src_rd_address;
  assign rd_in.burstcount = src_rd_burstcount;
  assign wr_in.address    = src_wr_address;
  assign wr_in.burstcount = src_wr_burstcount;
  assign wr_in.writedata  = src_wr_writedata;
  assign wr_in.byteenable = src_wr_byteenable;

  ofs_plat_avalon_allowance_fifo #(
    .WIDTH($bits(rd_cmd_t)), .DEPTH(FIFO_DEPTH), .ALLOWANCE(WAIT_REQUEST_ALLOWANCE)
  ) u_rd (
    .clk, .reset_n,
    .push(src_rd_read), .push_data(rd_in), .waitrequest(src_rd_waitrequest),
    .valid(snk_rd_read), .head(rd_head), .ready(!snk_rd_waitrequest),
    .overflow_err(overflow_err[0])
  );

  ofs_plat_avalon_allowance_fifo #(
    .WIDTH($bits(wr_cmd_t)), .DEPTH(FIFO_DEPTH), .ALLOWANCE(WAIT_REQUEST_ALLOWANCE)
  ) u_wr (
    .clk, .reset_n,
    .push(src_wr_write), .push_data(wr_in), .waitrequest(src_wr_waitrequest),
    .valid(snk_wr_write), .head(wr_head), .ready(!snk_wr_waitrequest),
    .overflow_err(overflow_err[1])
  );

  assign snk_rd_address    = rd_head.address;
  assign snk_rd_burstcount = rd_head.burstcount;
  assign snk_wr_address    = wr_head.address;
  assign snk_wr_burstcount = wr_head.burstcount;
  assign snk_wr_writedata  = wr_head.writedata;
  assign snk_wr_byteenable = wr_head.byteenable;
endmodule

// File: tb/tb_ofs_plat_avalon_mem_rdwr_if_allowance_sink.sv
// Bench: queue-based model of the two allowance FIFOs, checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ofs_plat_avalon_mem_rdwr_if_allowance_sink;
  localparam int AW = 32, DW = 64, BW = 7, ALLOW = 2, DEPTH = 8;

  logic clk = 1'b0, reset_n;
  logic src_rd_read, src_rd_waitrequest, snk_rd_read, snk_rd_waitrequest;
  logic [AW-1:0] src_rd_address, snk_rd_address, src_wr_address, snk_wr_address;
  logic [BW-1:0] src_rd_burstcount, snk_rd_burstcount, src_wr_burstcount, snk_wr_burstcount;
  logic src_wr_write, src_wr_waitrequest, snk_wr_write, snk_wr_waitrequest;
  logic [DW-1:0] src_wr_writedata, snk_wr_writedata;
  logic [DW/8-1:0] src_wr_byteenable, snk_wr_byteenable;
  logic [1:0] overflow_err;

  ofs_plat_avalon_mem_rdwr_if_allowance_sink #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW),
    .WAIT_REQUEST_ALLOWANCE(ALLOW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .src_rd_read(src_rd_read), .src_rd_address(src_rd_address),
    .src_rd_burstcount(src_rd_burstcount), .src_rd_waitrequest(src_rd_waitrequest),
    .src_wr_write(src_wr_write), .src_wr_address(src_wr_address),
    .src_wr_burstcount(src_wr_burstcount), .src_wr_writedata(src_wr_writedata),
    .src_wr_byteenable(src_wr_byteenable), .src_wr_waitrequest(src_wr_waitrequest),
    .snk_rd_read(snk_rd_read), .snk_rd_address(snk_rd_address),
    .snk_rd_burstcount(snk_rd_burstcount), .snk_rd_waitrequest(snk_rd_waitrequest),
    .snk_wr_write(snk_wr_write), .snk_wr_address(snk_wr_address),
    .snk_wr_burstcount(snk_wr_burstcount), .snk_wr_writedata(snk_wr_writedata),
    .snk_wr_byteenable(snk_wr_byteenable), .snk_wr_waitrequest(snk_wr_waitrequest),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [AW-1:0] a; logic [BW-1:0] b; } rd_t;
  typedef struct packed { logic [AW-1:0] a; logic [BW-1:0] b; logic [DW-1:0] d; logic [DW/8-1:0] e; } wr_t;

  rd_t rq[$];
  wr_t wq[$];
  wr_t wr_popped[$];
  logic rwait_m, wwait_m;
  logic [1:0] ovf_m;
  int n_chk = 0, n_fail = 0, rd_pops = 0, rcred = 0, wcred = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs against the model's queues and occupancy-derived backpressure.
  task automatic compare();
    chk("snk_rd_read", 64'(snk_rd_read), 64'(rq.size() != 0));
    if (rq.size() != 0) begin
      chk("snk_rd_address", 64'(snk_rd_address), 64'(rq[0].a));
      chk("snk_rd_burstcount", 64'(snk_rd_burstcount), 64'(rq[0].b));
    end
    chk("snk_wr_write", 64'(snk_wr_write), 64'(wq.size() != 0));
    if (wq.size() != 0) begin
      chk("snk_wr_address", 64'(snk_wr_address), 64'(wq[0].a));
      chk("snk_wr_burstcount", 64'(snk_wr_burstcount), 64'(wq[0].b));
      chk("snk_wr_writedata", snk_wr_writedata, wq[0].d);
      chk("snk_wr_byteenable", 64'(snk_wr_byteenable), 64'(wq[0].e));
    end
    chk("src_rd_waitrequest", 64'(src_rd_waitrequest), 64'(rwait_m));
    chk("src_wr_waitrequest", 64'(src_wr_waitrequest), 64'(wwait_m));
    chk("overflow_err", 64'(overflow_err), 64'(ovf_m));
  endtask

  // One clock: model consumes the inputs held across the edge, then check.
  task automatic step();
    bit rpop, wpop;
    rd_t r;
    wr_t w;
    rpop = (rq.size() != 0) && !snk_rd_waitrequest;
    wpop = (wq.size() != 0) && !snk_wr_waitrequest;
    r.a = src_rd_address; r.b = src_rd_burstcount;
    w.a = src_wr_address; w.b = src_wr_burstcount; w.d = src_wr_writedata; w.e = src_wr_byteenable;
    @(posedge clk);
    if (rpop) begin void'(rq.pop_front()); rd_pops++; end
    if (wpop) wr_popped.push_back(wq.pop_front());
    if (src_rd_read) begin
      if (rq.size() < DEPTH) rq.push_back(r);
`ifdef OFS_PLAT_AVALON_ALLOWANCE_CHECK_EN
      else ovf_m[0] = 1'b1;
`endif
    end
    if (src_wr_write) begin
      if (wq.size() < DEPTH) wq.push_back(w);
`ifdef OFS_PLAT_AVALON_ALLOWANCE_CHECK_EN
      else ovf_m[1] = 1'b1;
`endif
    end
    rwait_m = rq.size() > DEPTH - ALLOW - 1;
    wwait_m = wq.size() > DEPTH - ALLOW - 1;
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    src_rd_read = 0; src_wr_write = 0;
    snk_rd_waitrequest = 0; snk_wr_waitrequest = 0;
  endtask

  task automatic drive_rd(input logic [AW-1:0] a, input logic [BW-1:0] b);
    src_rd_read = 1; src_rd_address = a; src_rd_burstcount = b;
  endtask

  task automatic drive_wr(input logic [DW-1:0] d);
    src_wr_write = 1; src_wr_address = $urandom; src_wr_burstcount = BW'($urandom);
    src_wr_writedata = d; src_wr_byteenable = 8'($urandom);
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < DEPTH + 2; i++) step();
  endtask

  // Reset asserted mid-cycle; outputs must react without a clock edge.
  task automatic pulse_reset();
    idle();
    #2 reset_n = 0;
    #1;
    chk("rst_snk_rd_read", 64'(snk_rd_read), 64'd0);
    chk("rst_snk_wr_write", 64'(snk_wr_write), 64'd0);
    chk("rst_src_rd_wait", 64'(src_rd_waitrequest), 64'd1);
    chk("rst_src_wr_wait", 64'(src_wr_waitrequest), 64'd1);
    chk("rst_overflow_err", 64'(overflow_err), 64'd0);
    rq.delete(); wq.delete();
    rwait_m = 1; wwait_m = 1; ovf_m = 0;
    repeat (2) @(negedge clk);
    compare();
    reset_n = 1;
    compare();
  endtask

  logic [DW-1:0] base;
  int pushes;

  initial begin
    reset_n = 0;
    idle();
    src_rd_address = 0; src_rd_burstcount = 0; src_wr_address = 0;
    src_wr_burstcount = 0; src_wr_writedata = 0; src_wr_byteenable = 0;
    rwait_m = 1; wwait_m = 1; ovf_m = 0;
    repeat (3) @(negedge clk);
    chk("reset_snk_rd_read", 64'(snk_rd_read), 64'd0);
    chk("reset_snk_wr_write", 64'(snk_wr_write), 64'd0);
    chk("reset_src_rd_wait", 64'(src_rd_waitrequest), 64'd1);
    chk("reset_src_wr_wait", 64'(src_wr_waitrequest), 64'd1);
    chk("reset_overflow_err", 64'(overflow_err), 64'd0);
    reset_n = 1;
    compare();

    // Single read, sink ready: visible one cycle after push, for one cycle.
    drive_rd(32'h100, 7'd4);
    step();
    src_rd_read = 0;
    chk("single_rd_read", 64'(snk_rd_read), 64'd1);
    chk("single_rd_addr", 64'(snk_rd_address), 64'h100);
    chk("single_rd_burst", 64'(snk_rd_burstcount), 64'd4);
    chk("single_rd_wait", 64'(src_rd_waitrequest), 64'd0);
    step();
    chk("single_rd_gone", 64'(snk_rd_read), 64'd0);
    chk("single_rd_pops", 64'(rd_pops), 64'd1);

    // Sink stalled, source honours the allowance: exactly DEPTH beats land.
    snk_wr_waitrequest = 1;
    base = 64'hA000_0000_0000_0000;
    pushes = 0; wcred = ALLOW;
    for (int i = 0; i < 12; i++) begin
      if (!src_wr_waitrequest) wcred = ALLOW;
      if (!src_wr_waitrequest || wcred > 0) begin
        if (src_wr_waitrequest) wcred--;
        drive_wr(base + 64'(pushes));
        pushes++;
      end else src_wr_write = 0;
      step();
      if (src_wr_write && pushes == 5) chk("wr_wait_at_5", 64'(src_wr_waitrequest), 64'd0);
      if (src_wr_write && pushes == 6) chk("wr_wait_at_6", 64'(src_wr_waitrequest), 64'd1);
    end
    chk("allow_pushes", 64'(pushes), 64'd8);
    chk("allow_queued", 64'(wq.size()), 64'd8);
    chk("allow_wr_wait", 64'(src_wr_waitrequest), 64'd1);
    chk("allow_overflow", 64'(overflow_err), 64'd0);
    wr_popped.delete();
    drain();
    chk("allow_delivered", 64'(wr_popped.size()), 64'd8);
    for (int k = 0; k < wr_popped.size(); k++)
      chk("allow_order", wr_popped[k].d, base + 64'(k));

    // Both full, then simultaneous push/pop for 20 cycles on each channel.
    snk_rd_waitrequest = 1; snk_wr_waitrequest = 1;
    for (int i = 0; i < DEPTH; i++) begin
      drive_rd($urandom, BW'($urandom)); drive_wr({$urandom, $urandom});
      step();
    end
    snk_rd_waitrequest = 0; snk_wr_waitrequest = 0;
    rd_pops = 0; wr_popped.delete();
    for (int i = 0; i < 20; i++) begin
      drive_rd($urandom, BW'($urandom)); drive_wr({$urandom, $urandom});
      step();
      chk("full_rd_wait", 64'(src_rd_waitrequest), 64'd1);
    end
    chk("full_rd_count", 64'(rq.size()), 64'd8);
    chk("full_wr_count", 64'(wq.size()), 64'd8);
    chk("full_rd_pops", 64'(rd_pops), 64'd20);
    chk("full_wr_pops", 64'(wr_popped.size()), 64'd20);
    drain();

    // Overflow: 9th write into a full, stalled FIFO is dropped.
    snk_wr_waitrequest = 1;
    base = 64'hB000_0000_0000_0000;
    for (int i = 0; i < DEPTH; i++) begin drive_wr(base + 64'(i)); step(); end
    drive_wr(64'hDEAD);
    step();
    src_wr_write = 0;
    step();
`ifdef OFS_PLAT_AVALON_ALLOWANCE_CHECK_EN
    chk("ovf_flag", 64'(overflow_err), 64'd2);
`else
    chk("ovf_flag", 64'(overflow_err), 64'd0);
`endif
    wr_popped.delete();
    drain();
    chk("ovf_delivered", 64'(wr_popped.size()), 64'd8);
    for (int k = 0; k < wr_popped.size(); k++)
      chk("ovf_order", wr_popped[k].d, base + 64'(k));

    // Reset with five queued reads: nothing stale after release.
    snk_rd_waitrequest = 1;
    for (int i = 0; i < 5; i++) begin drive_rd($urandom, BW'($urandom)); step(); end
    chk("pre_rst_rd_read", 64'(snk_rd_read), 64'd1);
    pulse_reset();
    step(); step();
    chk("post_rst_rd_read", 64'(snk_rd_read), 64'd0);
    chk("post_rst_rd_wait", 64'(src_rd_waitrequest), 64'd0);

    // Random traffic within the allowance, with one mid-traffic reset.
    rcred = ALLOW; wcred = ALLOW;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) pulse_reset();
      snk_rd_waitrequest = ($urandom_range(0, 9) < 4);
      snk_wr_waitrequest = ($urandom_range(0, 9) < 4);
      if (!src_rd_waitrequest) rcred = ALLOW;
      if (!src_wr_waitrequest) wcred = ALLOW;
      if ($urandom_range(0, 3) != 0 && (!src_rd_waitrequest || rcred > 0)) begin
        if (src_rd_waitrequest) rcred--;
        drive_rd($urandom, BW'($urandom_range(1, 127)));
      end else src_rd_read = 0;
      if ($urandom_range(0, 3) != 0 && (!src_wr_waitrequest || wcred > 0)) begin
        if (src_wr_waitrequest) wcred--;
        drive_wr({$urandom, $urandom});
      end else src_wr_write = 0;
      step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
